ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 163 ++++++++++++++++
 tb/tb_ex_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an optional 32-step shift-add multiplier.
// Define EX_STAGE_MUL_EN to build the iterative MUL; otherwise MUL returns 0 in one cycle.
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_1_in,
  input  logic [DATA_W-1:0] data_2_in,
  input  logic [4:0]        rd_in,
  input  logic [2:0]        op_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] result_out,
  output logic [4:0]        rd_out,
  output logic              valid_out,
  output logic              stall_out
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_SLT:  alu = (sa < sb) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      OP_SLL:  alu = a << b[4:0];
      default: alu = '0;
    endcase
  endfunction

  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        rd_q, rd_d;
  logic              valid_q, valid_d;

`ifdef EX_STAGE_MUL_EN
  typedef enum logic {S_IDLE, S_MUL_BUSY} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mca_q, mca_d;
  logic [DATA_W-1:0] mcb_q, mcb_d;
  logic [4:0]        mrd_q, mrd_d;
  logic [DATA_W-1:0] step;
  logic              stall_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mca_d    = mca_q;
    mcb_d    = mcb_q;
    mrd_d    = mrd_q;
    result_d = result_q;
    rd_d     = rd_q;
    valid_d  = 1'b0;
    stall_c  = 1'b0;
    // mca/mcb shift each step so bit 0 of mcb selects the correctly aligned A
    step     = acc_q + (mcb_q[0] ? mca_q : '0);
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (op_in == OP_MUL) begin
            stall_c = 1'b1;
            state_d = S_MUL_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            mca_d   = data_1_in;
            mcb_d   = data_2_in;
            mrd_d   = rd_in;
          end else begin
            result_d = (rd_in == 5'd0) ? '0 : alu(op_in, data_1_in, data_2_in);
            rd_d     = rd_in;
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        acc_d = step;
        mca_d = mca_q << 1;
        mcb_d = mcb_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = S_IDLE;
          result_d = (mrd_q == 5'd0) ? '0 : step;
          rd_d     = mrd_q;
          valid_d  = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    mca_q <= mca_d;
    mcb_q <= mcb_d;
    mrd_q <= mrd_d;
  end

  // Gated by rst so an aborted multiply releases upstream immediately
  assign stall_out = rst & stall_c;
`else
  always_comb begin
    result_d = result_q;
    rd_d     = rd_q;
    valid_d  = 1'b0;
    if (valid_in) begin
      result_d = (rd_in == 5'd0) ? '0 : alu(op_in, data_1_in, data_2_in);
      rd_d     = rd_in;
      valid_d  = 1'b1;
    end
  end

  assign stall_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
    end
  end

  assign result_out = result_q;
  assign rd_out     = rd_q;
  assign valid_out  = valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes expected result/rd/cycle, a monitor pops on valid_out.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_1_in = '0;
  logic [31:0] data_2_in = '0;
  logic [4:0]  rd_in = '0;
  logic [2:0]  op_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] result_out;
  logic [4:0]  rd_out;
  logic        valid_out;
  logic        stall_out;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .data_1_in  (data_1_in),
    .data_2_in  (data_2_in),
    .rd_in      (rd_in),
    .op_in      (op_in),
    .valid_in   (valid_in),
    .result_out (result_out),
    .rd_out     (rd_out),
    .valid_out  (valid_out),
    .stall_out  (stall_out)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got result=%h rd=%0d at cycle %0d, required no output",
                 result_out, rd_out, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (result_out !== mon_e.res || rd_out !== mon_e.rd || cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL result: got %h rd=%0d cycle %0d, required %h rd=%0d cycle %0d",
                   result_out, rd_out, cyc, mon_e.res, mon_e.rd, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res,
                       input int lat, input int exp_stall);
    int n;
    @(posedge clk); #1;
    valid_in = 1'b1; op_in = op; data_1_in = a; data_2_in = b; rd_in = rd;
    sb_q.push_back('{exp_res, rd, cyc + lat});
    #1;
    n = 0;
    while (stall_out === 1'b1 && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("stall_cycles", n, exp_stall);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  initial begin
    int guard;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_out, 32'h0);
    check("rst_rd", {27'b0, rd_out}, 32'h0);
    check("rst_valid", {31'b0, valid_out}, 32'h0);
    check("rst_stall", {31'b0, stall_out}, 32'h0);
    rst = 1'b1;

    issue(3'd0, 32'd5,        32'd7,        5'd3, 32'd12,        1, 0);
    issue(3'd1, 32'd0,        32'd1,        5'd4, 32'hFFFF_FFFF, 1, 0);
    issue(3'd5, 32'hFFFF_FFFF, 32'd1,       5'd5, 32'd1,         1, 0);
    issue(3'd6, 32'd1,        32'h25,       5'd6, 32'h20,        1, 0);
    issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 32'hF000_F000, 1, 0);
    issue(3'd3, 32'h0F0F_0000, 32'h0000_00FF, 5'd8, 32'h0F0F_00FF, 1, 0);
    issue(3'd4, 32'hFFFF_0000, 32'hFF00_FF00, 5'd9, 32'h00FF_FF00, 1, 0);
    issue(3'd5, 32'd1,        32'hFFFF_FFFF, 5'd10, 32'd0,       1, 0);
    issue(3'd0, 32'hFFFF_FFFF, 32'd2,       5'd11, 32'd1,        1, 0);
    issue(3'd0, 32'd1,        32'd1,        5'd0, 32'd0,         1, 0);
`ifdef EX_STAGE_MUL_EN
    issue(3'd7, 32'd123,      32'd456,      5'd9,  32'd56088,    33, 32);
    issue(3'd0, 32'd1,        32'd2,        5'd10, 32'd3,        1, 0);
    issue(3'd7, 32'hFFFF_FFFF, 32'd2,       5'd11, 32'hFFFF_FFFE, 33, 32);
    issue(3'd7, 32'd3,        32'd4,        5'd12, 32'd12,       33, 32);
    issue(3'd7, 32'h0001_0000, 32'h0001_0000, 5'd13, 32'd0,      33, 32);
    issue(3'd7, 32'd7,        32'd7,        5'd0,  32'd0,        33, 32);
`else
    issue(3'd7, 32'd3,        32'd4,        5'd9,  32'd0,        1, 0);
`endif

    // output registers hold while no instruction arrives
    issue(3'd0, 32'h11,       32'h22,       5'd7,  32'h33,       1, 0);
    idle(3);
    check("hold_result", result_out, 32'h33);
    check("hold_rd", {27'b0, rd_out}, 32'd7);
    check("hold_valid", {31'b0, valid_out}, 32'h0);

`ifdef EX_STAGE_MUL_EN
    // multiply aborted by reset ten cycles in
    @(posedge clk); #1;
    valid_in = 1'b1; op_in = 3'd7; data_1_in = 32'd9; data_2_in = 32'd9; rd_in = 5'd4;
    repeat (10) @(posedge clk);
    #1;
    check("abort_stall_before", {31'b0, stall_out}, 32'h1);
`else
    @(posedge clk); #1;
    valid_in = 1'b0;
`endif
    rst = 1'b0;
    #1;
    check("abort_result", result_out, 32'h0);
    check("abort_rd", {27'b0, rd_out}, 32'h0);
    check("abort_valid", {31'b0, valid_out}, 32'h0);
    check("abort_stall", {31'b0, stall_out}, 32'h0);
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    issue(3'd0, 32'd2, 32'd3, 5'd1, 32'd5, 1, 0);
    idle(40);

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
